// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and validates the image with an XOR sum.
// Ports: clk, rst (async, active-high); start; byte stream in_valid/in_data/in_ready;
// memory write im_we/im_addr/im_wdata; status cpu_hold, busy, done, err, words_loaded.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]     count;
  logic [7:0]        csum;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic [ADDR_W-1:0] word_idx;
  logic              xfer;
  logic              last_word;

  assign xfer      = in_valid & in_ready;
  assign last_word = (words_loaded + CW'(1)) == count;

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state)
      HDR, DATA, CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE:   busy = 1'b1;
      default: ;
    endcase
  end

  assign cpu_hold = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (start) next_state = HDR;
      HDR:
        if (xfer) next_state = DATA;
      DATA:
        if (xfer && byte_idx == 2'd3) next_state = WRITE;
      WRITE:
        next_state = last_word ? CSUM : DATA;
      CSUM:
        if (xfer) next_state = (in_data == csum) ? DONE : ERR;
      default:
        next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      csum         <= '0;
      byte_idx     <= '0;
      word         <= '0;
      word_idx     <= '0;
    end else begin
      im_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            word_idx     <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            // A zero header means a full memory image.
            count    <= (in_data == 8'd0) ? CW'(256) : CW'(in_data);
            csum     <= in_data;
            byte_idx <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word[7:0]   <= in_data;
              2'd1: word[15:8]  <= in_data;
              2'd2: word[23:16] <= in_data;
              default: begin
                // Fourth byte goes straight to the write port;
                // im_we is high for exactly the WRITE cycle.
                im_we    <= 1'b1;
                im_addr  <= ADDR_W'(BASE_ADDR) + word_idx;
                im_wdata <= {in_data, word};
              end
            endcase
          end
        end
        WRITE: begin
          word_idx     <= word_idx + ADDR_W'(1);
          words_loaded <= words_loaded + CW'(1);
          byte_idx     <= '0;
        end
        CSUM: begin
          if (xfer) begin
            if (in_data == csum) done <= 1'b1;
            else                 err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: writes a program into the 256x32 word-addressed instruction memory before the pipelined CPU runs.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives a single-port instruction-memory write interface: the writer side of the instruction-fetch read path.
- Holds the CPU while loading and checks the stream with an XOR checksum.

Parameters:
ADDR_W, 8, instruction-memory word-address width (256 words).
BASE_ADDR, 0, first word address written; addresses wrap modulo 2^ADDR_W.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
in_valid  input  1  in_data holds a valid byte.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready).
im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
im_addr  output  ADDR_W  instruction-memory write word address.
im_wdata  output  32  instruction-memory write data.
cpu_hold  output  1  stalls the CPU / PC; high while loading.
busy  output  1  high in HDR, DATA, WRITE and CSUM.
done  output  1  load finished and checksum matched; sticky.
err  output  1  checksum mismatch; sticky.
words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, immediate, also mid-load):
  - State returns to IDLE.
  - All outputs go to 0: im_we, im_addr, im_wdata, done, err, words_loaded, cpu_hold, busy, in_ready.
  - Any partially assembled word is discarded.
- Outputs:
  - im_we, im_addr, im_wdata, done, err and words_loaded are registered.
  - in_ready, busy and cpu_hold decode from the state register only, with no combinational path from inputs.
  - cpu_hold equals busy.
- States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: in_ready=0. On start, go to HDR and clear done, err and words_loaded.
- HDR: in_ready=1.
  - On transfer: count = (in_data==0) ? 256 : in_data; csum = in_data; byte_idx=0; go to DATA.
- DATA: in_ready=1.
  - On transfer: byte byte_idx is stored in word bits [8*byte_idx+7 : 8*byte_idx]; csum ^= in_data; byte_idx++.
  - After the 4th byte, go to WRITE.
  - Cycles without in_valid are idle and change no state.
- WRITE: exactly one cycle; in_ready=0.
  - Registered im_we=1 with im_addr = (BASE_ADDR + word_idx) mod 2^ADDR_W and im_wdata = assembled word.
  - Next cycle: im_we returns to 0, word_idx++, words_loaded++.
  - If words_loaded has reached count, go to CSUM; otherwise go to DATA with byte_idx=0.
- Byte held during WRITE: a byte presented with in_valid during WRITE is not consumed. The source must hold it, and it is accepted in the next DATA or CSUM cycle.
- CSUM: in_ready=1. On transfer, go to DONE with done=1 if in_data==csum; otherwise go to ERR with err=1.
- DONE and ERR: in_ready=0, cpu_hold=0. The flag stays set until the next start, which clears it and enters HDR.
- start while busy is ignored.
- im_addr and im_wdata hold their last values when im_we=0.
- Throughput: at best 5 cycles per word (4 byte cycles + 1 write cycle).
- Writes already committed before a checksum error are not undone; err only flags the image as invalid.
- words_loaded saturates naturally at 256; 9 bits are required for ADDR_W=8.

Test Plan:
- Single word, normal load:
  - Stimulus: start, then bytes 01,78,56,34,12,09 with in_valid held high.
  - Response: one im_we pulse with im_addr=00 and im_wdata=0x12345678; words_loaded=1; done=1; err=0.
  - cpu_hold is high from the cycle after start until DONE.
- Checksum mismatch:
  - Stimulus: same stream as above, but checksum byte 0x08.
  - Response: the write to address 00 still occurs; err=1; done=0; cpu_hold=0 afterwards.
- Address wrap:
  - Stimulus: BASE_ADDR=0xFE, header 03, 12 data bytes, correct checksum.
  - Response: writes land at addresses FE, FF, 00 in that order; words_loaded=3; done=1.
- Full image:
  - Stimulus: header 00 (meaning 256 words).
  - Response: exactly 256 im_we pulses at addresses 00 to FF; words_loaded=256; done only after the checksum byte.
- Handshake gaps and byte held during WRITE:
  - Stimulus: toggle in_valid randomly, and present a byte during WRITE.
  - Response: that byte is not consumed while in_ready=0; the assembled words are identical to the gap-free run; exactly one im_we per word.
- Reset and restart:
  - Stimulus: assert rst mid-DATA, while im_we is high, or mid-WRITE.
  - Response: im_we, busy and cpu_hold drop to 0 immediately without waiting for a clock edge.
  - A subsequent start with a fresh stream loads correctly from BASE_ADDR.
  - A start pulse issued while busy is ignored.
